morse_key_decoder: RTL and testbench

Input-side counterpart to the tone generator: samples a raw Morse key, debounces it, times each press and release on `clk_lc`, classifies presses as dot or dash and packs them into a letter code. It emits one code per letter after an inter-letter gap, and feeds the character lookup stage of the decoder.

---
 rtl/morse_key_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_morse_key_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// morse_key_decoder : debounced Morse key timer packing dots/dashes into codes.
// Optional word-space pulse built with MORSE_WORD_GAP_EN.  Revision 1.0
// ---------------------------------------------------------------------------
module morse_key_decoder #(
    parameter int DEBOUNCE   = 4,
    parameter int DASH_MIN   = 20,
    parameter int LETTER_GAP = 40,
    parameter int WORD_GAP   = 100,
    parameter int CNT_W      = 16
) (
    input  logic       clk_lc,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_level,
    output logic [4:0] code_out,
    output logic [2:0] len_out,
    output logic       code_valid,
    output logic       overflow,
    output logic       word_space
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] LGAP_C   = CNT_W'(LETTER_GAP);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d, level_prev_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] press_q, press_d, gap_q, gap_d;
    logic [CNT_W-1:0] press_inc, gap_inc;
    logic [4:0]       buf_q, buf_d, code_q, code_d;
    logic [2:0]       len_q, len_d, clen_q, clen_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;
    logic             rise, fall;

`ifdef MORSE_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WGAP_C = CNT_W'(WORD_GAP);
    logic armed_q, armed_d, ws_q, ws_d;
    assign word_space = ws_q;
`else
    logic unused_word_gap;
    assign unused_word_gap = ^WORD_GAP;
    assign word_space      = 1'b0;
`endif

    assign key_level  = level_q;
    assign code_out   = code_q;
    assign len_out    = clen_q;
    assign code_valid = valid_q;
    assign overflow   = ovf_q;

    // Edges are taken from the registered level, so the FSM acts one cycle after key_level moves.
    assign rise      = level_q & ~level_prev_q;
    assign fall      = ~level_q & level_prev_q;
    assign press_inc = (press_q == CNT_MAX) ? press_q : press_q + 1'b1;
    assign gap_inc   = (gap_q == CNT_MAX) ? gap_q : gap_q + 1'b1;

    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        press_d = press_q;
        gap_d   = gap_q;
        buf_d   = buf_q;
        len_d   = len_q;
        code_d  = code_q;
        clen_d  = clen_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
`ifdef MORSE_WORD_GAP_EN
        armed_d = armed_q;
        ws_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS;
                    press_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    gap_d   = '0;
`ifdef MORSE_WORD_GAP_EN
                    armed_d = 1'b0;
                end else if (armed_q) begin
                    gap_d = gap_inc;
                    if (gap_inc == WGAP_C) begin
                        ws_d    = 1'b1;
                        armed_d = 1'b0;
                        gap_d   = '0;
                    end
`endif
                end
            end
            S_PRESS: begin
                press_d = press_inc;
                if (fall) begin
                    press_d = '0;
                    gap_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    if (len_q == 3'd5) begin
                        ovf_d   = 1'b1;
                        buf_d   = '0;
                        len_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        buf_d[len_q] = (press_q >= DASH_C);
                        len_d        = len_q + 1'b1;
                        state_d      = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_inc;
                if (gap_inc == LGAP_C) begin
                    valid_d = 1'b1;
                    code_d  = buf_q;
                    clen_d  = len_q;
                    buf_d   = '0;
                    len_d   = '0;
                end
                // A rise coinciding with emission still starts a fresh press.
                if (rise) begin
                    state_d = S_PRESS;
                    press_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    gap_d   = '0;
                end else if (gap_inc == LGAP_C) begin
                    state_d = S_IDLE;
`ifdef MORSE_WORD_GAP_EN
                    armed_d = 1'b1;
`else
                    gap_d   = '0;
`endif
                end
            end
            default: begin
                if (level_q) begin
                    gap_d = '0;
                end else if (gap_inc == LGAP_C) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk_lc or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            state_q      <= S_IDLE;
            press_q      <= '0;
            gap_q        <= '0;
            buf_q        <= '0;
            len_q        <= '0;
            code_q       <= '0;
            clen_q       <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            armed_q      <= 1'b0;
            ws_q         <= 1'b0;
`endif
        end else begin
            sync1_q      <= key_in;
            sync2_q      <= sync1_q;
            deb_cnt_q    <= deb_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            state_q      <= state_d;
            press_q      <= press_d;
            gap_q        <= gap_d;
            buf_q        <= buf_d;
            len_q        <= len_d;
            code_q       <= code_d;
            clen_q       <= clen_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
`ifdef MORSE_WORD_GAP_EN
            armed_q      <= armed_d;
            ws_q         <= ws_d;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_morse_key_decoder : directed self-checking bench for morse_key_decoder.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_morse_key_decoder;
    logic       clk_lc = 1'b0;
    logic       rst;
    logic       key_in;
    logic       key_level;
    logic [4:0] code_out;
    logic [2:0] len_out;
    logic       code_valid;
    logic       overflow;
    logic       word_space;

    int nassert = 0;
    int nfail   = 0;
    int cyc     = 0;

    // Event log written only by the monitor
    int         nv = 0, no = 0, nws = 0;
    logic [4:0] vcode [0:63];
    logic [2:0] vlen  [0:63];
    int         vcyc  [0:63];
    int         vfall [0:63];
    int         ocyc = 0, ofall = 0, wcyc = 0, wfall = 0;
    int         last_rise = 0, last_fall = 0;
    logic       lvl_prev = 1'b0;

    int base_v, base_o, base_w, set_cyc;

    morse_key_decoder #(
        .DEBOUNCE  (4),
        .DASH_MIN  (20),
        .LETTER_GAP(40),
        .WORD_GAP  (100),
        .CNT_W     (16)
    ) dut (
        .clk_lc    (clk_lc),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (key_level),
        .code_out  (code_out),
        .len_out   (len_out),
        .code_valid(code_valid),
        .overflow  (overflow),
        .word_space(word_space)
    );

    always #5 clk_lc = ~clk_lc;

    always @(posedge clk_lc) cyc <= cyc + 1;

    always @(negedge clk_lc) begin
        if (key_level && !lvl_prev) last_rise = cyc;
        if (!key_level && lvl_prev) last_fall = cyc;
        lvl_prev = key_level;
        if (code_valid && nv < 64) begin
            vcode[nv] = code_out;
            vlen[nv]  = len_out;
            vcyc[nv]  = cyc;
            vfall[nv] = last_fall;
            nv++;
        end
        if (overflow) begin
            ocyc  = cyc;
            ofall = last_fall;
            no++;
        end
        if (word_space) begin
            wcyc  = cyc;
            wfall = last_fall;
            nws++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int n);
        key_in = 1'b1;
        repeat (n) @(negedge clk_lc);
    endtask

    task automatic release_key(input int n);
        key_in = 1'b0;
        repeat (n) @(negedge clk_lc);
    endtask

    task automatic snap();
        base_v = nv;
        base_o = no;
        base_w = nws;
    endtask

    initial begin
        key_in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk_lc);
        rst = 1'b0;

        // Reset then idle
        release_key(50);
        chk("reset key_level", int'(key_level), 0);
        chk("reset code_out", int'(code_out), 0);
        chk("reset len_out", int'(len_out), 0);
        chk("reset code_valid", int'(code_valid), 0);
        chk("idle valid count", nv, 0);
        chk("idle overflow count", no, 0);
        chk("idle word_space count", nws, 0);

        // Letter A: dot then dash; also debounce latency on both edges
        snap();
        set_cyc = cyc;
        press(10);
        chk("rise latency", last_rise - set_cyc, 6);
        release_key(10);
        press(30);
        set_cyc = cyc;
        release_key(60);
        chk("fall latency", last_fall - set_cyc, 6);
        chk("A valid count", nv - base_v, 1);
        chk("A code", int'(vcode[base_v]), 5'b00010);
        chk("A len", int'(vlen[base_v]), 2);
        chk("A valid delay", vcyc[base_v] - vfall[base_v], 40);
        release_key(20);
        chk("A code held", int'(code_out), 5'b00010);
        chk("A len held", int'(len_out), 2);

        // Press broken by a short release glitch stays one dot
        snap();
        press(5);
        release_key(2);
        press(5);
        release_key(60);
        chk("glitch valid count", nv - base_v, 1);
        chk("glitch code", int'(vcode[base_v]), 0);
        chk("glitch len", int'(vlen[base_v]), 1);

        // Dash threshold boundary
        snap();
        press(19);
        release_key(60);
        press(20);
        release_key(60);
        chk("dash bound count", nv - base_v, 2);
        chk("press 19 code", int'(vcode[base_v]), 0);
        chk("press 20 code", int'(vcode[base_v+1]), 1);
        chk("press 20 len", int'(vlen[base_v+1]), 1);

        // Release of 38 keeps the letter open
        snap();
        press(10);
        release_key(38);
        press(10);
        release_key(60);
        chk("gap38 valid count", nv - base_v, 1);
        chk("gap38 len", int'(vlen[base_v]), 2);
        chk("gap38 code", int'(vcode[base_v]), 0);

        // Rise seen on the emission cycle: emit, then a new press
        snap();
        press(10);
        release_key(39);
        press(10);
        release_key(60);
        chk("collide valid count", nv - base_v, 2);
        chk("collide len first", int'(vlen[base_v]), 1);
        chk("collide len second", int'(vlen[base_v+1]), 1);
        chk("collide delay second", vcyc[base_v+1] - vfall[base_v+1], 40);

        // Six dots overflow the buffer
        snap();
        for (int i = 0; i < 6; i++) begin
            press(10);
            release_key(10);
        end
        release_key(50);
        chk("ovf count", no - base_o, 1);
        chk("ovf no valid", nv - base_v, 0);
        chk("ovf delay", ocyc - ofall, 1);
        snap();
        press(10);
        release_key(60);
        chk("post-ovf E count", nv - base_v, 1);
        chk("post-ovf E len", int'(vlen[base_v]), 1);

        // Reset mid-press discards a held dot
        snap();
        press(10);
        release_key(10);
        press(15);
        rst    = 1'b1;
        key_in = 1'b0;
        repeat (3) @(negedge clk_lc);
        rst = 1'b0;
        release_key(60);
        chk("rst no valid", nv - base_v, 0);
        chk("rst no overflow", no - base_o, 0);
        chk("rst len_out", int'(len_out), 0);
        press(10);
        release_key(60);
        chk("rst E count", nv - base_v, 1);
        chk("rst E code", int'(vcode[base_v]), 0);
        chk("rst E len", int'(vlen[base_v]), 1);

        // Word space
        snap();
        press(10);
        release_key(150);
        chk("E valid delay", vcyc[base_v] - vfall[base_v], 40);
`ifdef MORSE_WORD_GAP_EN
        chk("word_space count", nws - base_w, 1);
        chk("word_space delay", wcyc - wfall, 100);
`else
        chk("word_space absent", nws - base_w, 0);
        chk("word_space level", int'(word_space), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
`default_nettype wire
